// File: rtl/mvm_uart_pkg.sv
// Shared configuration for the UART matrix-vector multiplier: base parameters,
// derived bus widths and the RX/TX state encodings.
package mvm_uart_pkg;

  localparam int CLOCKS_PER_PULSE = 4;
  localparam int BITS_PER_WORD    = 8;
  localparam int PACKET_SIZE_TX   = BITS_PER_WORD + 5;
  localparam int R                = 1;
  localparam int C                = 1;
  localparam int W_X              = 8;
  localparam int W_K              = 8;
  localparam int W_Y_OUT          = 32;
  localparam int FIFO_DEPTH       = 16;

  localparam int W_Y        = W_X + W_K + $clog2(C);
  localparam int W_BUS_KX   = R*C*W_K + C*W_X;
  localparam int W_BUS_Y    = R*W_Y_OUT;
  localparam int N_WORDS_KX = W_BUS_KX / BITS_PER_WORD;
  localparam int N_WORDS_Y  = W_BUS_Y / BITS_PER_WORD;

  localparam int CW  = $clog2(CLOCKS_PER_PULSE);
  localparam int RBW = $clog2(BITS_PER_WORD);
  localparam int TBW = $clog2(PACKET_SIZE_TX);
  localparam int PW  = $clog2(FIFO_DEPTH);
  localparam int KCW = (N_WORDS_KX > 1) ? $clog2(N_WORDS_KX) : 1;
  localparam int YCW = (N_WORDS_Y > 1) ? $clog2(N_WORDS_Y) : 1;

  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_WAIT} rx_state_e;
  typedef enum logic       {TX_IDLE, TX_SEND} tx_state_e;

endpackage

// File: rtl/mvm_uart_if.sv
// Byte stream handshake: a one-cycle valid pulse qualifying a data word.
interface mvm_uart_if #(parameter int W = 8);
  logic         valid;
  logic [W-1:0] data;

  modport master (output valid, data);
  modport slave  (input  valid, data);
endinterface

// File: rtl/uart_rx.sv
// UART byte receiver: double-flop synchroniser, mid-bit sampling, and a
// one-cycle valid pulse for every byte whose stop bit reads high.
module uart_rx
  import mvm_uart_pkg::*;
(
  input  logic       clk,
  input  logic       rstn,
  input  logic       rx,
  mvm_uart_if.master byte_if
);

  localparam logic [CW-1:0] HALF_M1 = CW'(CLOCKS_PER_PULSE/2 - 1);
  localparam logic [CW-1:0] FULL_M1 = CW'(CLOCKS_PER_PULSE - 1);

  rx_state_e               state_q, state_d;
  logic                    rx_meta_q, rx_sync_q;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic [RBW-1:0]          bit_q, bit_d;
  logic [BITS_PER_WORD-1:0] shift_q, shift_d, data_q, data_d;
  logic                    valid_q, valid_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    data_d  = data_q;
    valid_d = 1'b0;
    case (state_q)
      RX_IDLE: begin
        cnt_d = '0;
        bit_d = '0;
        if (!rx_sync_q) state_d = RX_START;
      end
      // A start bit must still be low half a bit later, else it was a glitch.
      RX_START: begin
        if (cnt_q == HALF_M1) begin
          cnt_d   = '0;
          state_d = rx_sync_q ? RX_IDLE : RX_DATA;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      RX_DATA: begin
        if (cnt_q == FULL_M1) begin
          cnt_d   = '0;
          shift_d = {rx_sync_q, shift_q[BITS_PER_WORD-1:1]};
          if (bit_q == RBW'(BITS_PER_WORD - 1)) state_d = RX_STOP;
          else                                  bit_d   = bit_q + RBW'(1);
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      RX_STOP: begin
        if (cnt_q == FULL_M1) begin
          cnt_d = '0;
          if (rx_sync_q) begin
            valid_d = 1'b1;
            data_d  = shift_q;
            state_d = RX_IDLE;
          end else begin
            state_d = RX_WAIT;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      // After a framing error, wait for the line to recover before hunting again.
      RX_WAIT: if (rx_sync_q) state_d = RX_IDLE;
      default: state_d = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
      state_q   <= RX_IDLE;
      cnt_q     <= '0;
      bit_q     <= '0;
      shift_q   <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
    end else begin
      rx_meta_q <= rx;
      rx_sync_q <= rx_meta_q;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_q     <= bit_d;
      shift_q   <= shift_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
    end
  end

  assign byte_if.valid = valid_q;
  assign byte_if.data  = data_q;

endmodule

// File: rtl/mvm_uart_system.sv
// UART-attached signed matrix-vector multiplier: assembles K and X from rx bytes,
// queues Y = K*X in a result FIFO and serialises each result on tx.
module mvm_uart_system
  import mvm_uart_pkg::*;
(
  input  logic clk,
  input  logic rstn,
  input  logic rx,
  output logic tx
);

  mvm_uart_if #(.W(BITS_PER_WORD)) rx_byte_if ();

  uart_rx u_uart_rx (
    .clk     (clk),
    .rstn    (rstn),
    .rx      (rx),
    .byte_if (rx_byte_if)
  );

  logic [W_BUS_KX-1:0]      kx_q, kx_d;
  logic [KCW-1:0]           word_cnt_q, word_cnt_d;
  logic                     compute_q, compute_d;
  logic signed [W_K-1:0]    kv;
  logic signed [W_X-1:0]    xv;
  logic signed [W_Y-1:0]    prod, acc;
  logic [W_BUS_Y-1:0]       y_bus;

  logic [W_BUS_Y-1:0]       mem_q [FIFO_DEPTH];
  logic [PW-1:0]            wr_ptr_q, rd_ptr_q;
  logic [PW:0]              count_q;
  logic                     fifo_full, fifo_empty, push, pop;

  tx_state_e                tx_state_q, tx_state_d;
  logic [CW-1:0]            tx_cnt_q, tx_cnt_d;
  logic [TBW-1:0]           tx_bit_q, tx_bit_d, next_bit;
  logic [YCW-1:0]           tx_word_q, tx_word_d;
  logic [W_BUS_Y-1:0]       tx_shift_q, tx_shift_d;
  logic                     tx_q, tx_d;

  always_comb begin
    kx_d       = kx_q;
    word_cnt_d = word_cnt_q;
    compute_d  = 1'b0;
    if (rx_byte_if.valid) begin
      kx_d[word_cnt_q*BITS_PER_WORD +: BITS_PER_WORD] = rx_byte_if.data;
      if (word_cnt_q == KCW'(N_WORDS_KX - 1)) begin
        word_cnt_d = '0;
        compute_d  = 1'b1;
      end else begin
        word_cnt_d = word_cnt_q + KCW'(1);
      end
    end
  end

  // Full-precision signed dot product per row, then sign-extended into the Y bus.
  always_comb begin
    y_bus = '0;
    acc   = '0;
    prod  = '0;
    kv    = '0;
    xv    = '0;
    for (int r = 0; r < R; r++) begin
      acc = '0;
      for (int c = 0; c < C; c++) begin
        kv   = kx_q[C*W_X + (r*C + c)*W_K +: W_K];
        xv   = kx_q[c*W_X +: W_X];
        prod = W_Y'(kv) * W_Y'(xv);
        acc  = acc + prod;
      end
      y_bus[r*W_Y_OUT +: W_Y_OUT] = W_Y_OUT'(acc);
    end
  end

  assign fifo_full  = (count_q == (PW+1)'(FIFO_DEPTH));
  assign fifo_empty = (count_q == '0);
  assign push       = compute_q && (!fifo_full || pop);

  function automatic logic frame_bit(input logic [BITS_PER_WORD-1:0] b,
                                     input logic [TBW-1:0] idx);
    if (idx == '0) return 1'b0;
    if (int'(idx) <= BITS_PER_WORD) return b[idx - TBW'(1)];
    return 1'b1;
  endfunction

  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q;
    tx_bit_d   = tx_bit_q;
    tx_word_d  = tx_word_q;
    tx_shift_d = tx_shift_q;
    tx_d       = tx_q;
    pop        = 1'b0;
    next_bit   = tx_bit_q + TBW'(1);
    case (tx_state_q)
      TX_IDLE: begin
        tx_d = 1'b1;
        if (!fifo_empty) begin
          pop        = 1'b1;
          tx_shift_d = mem_q[rd_ptr_q];
          tx_cnt_d   = '0;
          tx_bit_d   = '0;
          tx_word_d  = '0;
          tx_state_d = TX_SEND;
          tx_d       = 1'b0;
        end
      end
      // The next result is chained straight after the last stop bit when available.
      TX_SEND: begin
        if (tx_cnt_q == CW'(CLOCKS_PER_PULSE - 1)) begin
          tx_cnt_d = '0;
          if (tx_bit_q == TBW'(PACKET_SIZE_TX - 1)) begin
            tx_bit_d = '0;
            if (tx_word_q != YCW'(N_WORDS_Y - 1)) begin
              tx_word_d  = tx_word_q + YCW'(1);
              tx_shift_d = tx_shift_q >> BITS_PER_WORD;
              tx_d       = 1'b0;
            end else if (!fifo_empty) begin
              pop        = 1'b1;
              tx_shift_d = mem_q[rd_ptr_q];
              tx_word_d  = '0;
              tx_d       = 1'b0;
            end else begin
              tx_state_d = TX_IDLE;
              tx_d       = 1'b1;
            end
          end else begin
            tx_bit_d = next_bit;
            tx_d     = frame_bit(tx_shift_q[BITS_PER_WORD-1:0], next_bit);
          end
        end else begin
          tx_cnt_d = tx_cnt_q + CW'(1);
        end
      end
      default: tx_state_d = TX_IDLE;
    endcase
  end

  // Reset leaves one zero result queued so the host always sees an initial frame.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q   <= PW'(1);
      rd_ptr_q   <= '0;
      count_q    <= (PW+1)'(1);
      kx_q       <= '0;
      word_cnt_q <= '0;
      compute_q  <= 1'b0;
      tx_state_q <= TX_IDLE;
      tx_cnt_q   <= '0;
      tx_bit_q   <= '0;
      tx_word_q  <= '0;
      tx_shift_q <= '0;
      tx_q       <= 1'b1;
    end else begin
      if (push) begin
        mem_q[wr_ptr_q] <= y_bus;
        wr_ptr_q        <= wr_ptr_q + PW'(1);
      end
      if (pop) rd_ptr_q <= rd_ptr_q + PW'(1);
      count_q    <= count_q + (PW+1)'(push) - (PW+1)'(pop);
      kx_q       <= kx_d;
      word_cnt_q <= word_cnt_d;
      compute_q  <= compute_d;
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_bit_q   <= tx_bit_d;
      tx_word_q  <= tx_word_d;
      tx_shift_q <= tx_shift_d;
      tx_q       <= tx_d;
    end
  end

  assign tx = tx_q;

endmodule

// File: tb/tb_mvm_uart_system.sv
// Scoreboard bench for mvm_uart_system: drives UART packets on rx, decodes tx
// frames into a byte stream and compares each byte against queued expectations.
module tb_mvm_uart_system;
  import mvm_uart_pkg::*;

  localparam int CPP = CLOCKS_PER_PULSE;
  localparam int PAD = PACKET_SIZE_TX - BITS_PER_WORD - 1;

  typedef struct {
    logic [7:0]  x;
    logic [7:0]  k;
    logic [31:0] y;
  } vec_t;

  logic       clk = 1'b0;
  logic       rstn = 1'b1;
  logic       rx = 1'b1;
  logic       tx;
  int         n_vec = 0;
  int         n_miss = 0;
  logic [7:0] exp_q[$];
  logic [7:0] want;
  vec_t       vecs[10];

  mvm_uart_if #(.W(8)) mon_if ();

  mvm_uart_system dut (
    .clk  (clk),
    .rstn (rstn),
    .rx   (rx),
    .tx   (tx)
  );

  always #5 clk = ~clk;

  task automatic check_output(input string name, input logic got, input logic req);
    n_vec++;
    if (got !== req) begin
      n_miss++;
      $display("[TB] FAIL %s: got %0b, required %0b at %0t", name, got, req, $time);
    end
  endtask

  task automatic expect_result(input logic [31:0] y);
    for (int b = 0; b < 4; b++) exp_q.push_back(y[b*8 +: 8]);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    @(negedge clk);
    rx = 1'b0;
    repeat (CPP) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (CPP) @(negedge clk);
    end
    rx = stop_bit;
    repeat (CPP) @(negedge clk);
    rx = 1'b1;
  endtask

  task automatic apply_packet(input logic [7:0] x, input logic [7:0] k,
                              input logic [31:0] y, input int gap);
    expect_result(y);
    send_byte(x, 1'b1);
    repeat (gap) @(negedge clk);
    send_byte(k, 1'b1);
  endtask

  task automatic drain(input int bound);
    for (int i = 0; i < bound && exp_q.size() != 0; i++) @(negedge clk);
    n_vec++;
    if (exp_q.size() != 0) begin
      n_miss++;
      $display("[TB] FAIL drain_timeout: %0d bytes still pending, required 0", exp_q.size());
    end
  endtask

  task automatic wait_n(input int n, output logic ok);
    ok = 1'b1;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (!rstn) begin
        ok = 1'b0;
        return;
      end
    end
  endtask

  // Frame decoder: mid-bit sampling of tx; a reset aborts the frame in flight.
  initial begin : decoder
    logic       ok;
    logic [7:0] d;
    mon_if.valid = 1'b0;
    mon_if.data  = '0;
    forever begin
      @(negedge clk);
      if (rstn && tx == 1'b0) begin
        d = '0;
        wait_n(CPP/2, ok);
        if (ok) check_output("start_bit", tx, 1'b0);
        for (int i = 0; i < 8 && ok; i++) begin
          wait_n(CPP, ok);
          if (ok) d[i] = tx;
        end
        for (int i = 0; i < PAD && ok; i++) begin
          wait_n(CPP, ok);
          if (ok) check_output("pad_bit", tx, 1'b1);
        end
        if (ok) begin
          mon_if.data  = d;
          mon_if.valid = 1'b1;
          @(posedge clk);
          #1 mon_if.valid = 1'b0;
        end
      end
    end
  end

  always @(posedge clk) begin
    if (mon_if.valid) begin
      n_vec++;
      if (exp_q.size() == 0) begin
        n_miss++;
        $display("[TB] FAIL unexpected_byte: got %02h, required none", mon_if.data);
      end else begin
        want = exp_q.pop_front();
        if (mon_if.data !== want) begin
          n_miss++;
          $display("[TB] FAIL tx_byte: got %02h, required %02h at %0t", mon_if.data, want, $time);
        end
      end
    end
  end

  initial begin : main
    vecs[0] = '{8'h05, 8'h07, 32'h0000_0023};
    vecs[1] = '{8'hFF, 8'h01, 32'hFFFF_FFFF};
    vecs[2] = '{8'h7F, 8'h7F, 32'h0000_3F01};
    vecs[3] = '{8'h10, 8'hF0, 32'hFFFF_FF00};
    vecs[4] = '{8'h00, 8'h55, 32'h0000_0000};
    vecs[5] = '{8'h0A, 8'h0C, 32'h0000_0078};
    vecs[6] = '{8'hFE, 8'hFD, 32'h0000_0006};
    vecs[7] = '{8'h64, 8'h9C, 32'hFFFF_D8F0};
    vecs[8] = '{8'h81, 8'h02, 32'hFFFF_FF02};
    vecs[9] = '{8'h33, 8'h03, 32'h0000_0099};

    #2 rstn = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check_output("reset_tx", tx, 1'b1);
    end
    expect_result(32'h0);
    rstn = 1'b1;

    apply_packet(8'h03, 8'hFE, 32'hFFFF_FFFA, 2);
    apply_packet(8'h80, 8'h80, 32'h0000_4000, 2);
    apply_packet(8'h7F, 8'h80, 32'hFFFF_C080, 2);
    drain(3000);

    // Backlog: packets arrive faster than results drain, so the FIFO queues them.
    foreach (vecs[i]) begin
      apply_packet(vecs[i].x, vecs[i].k, vecs[i].y, $urandom_range(1, 20));
      repeat ($urandom_range(1, 100)) @(negedge clk);
    end
    drain(6000);

    expect_result(32'h0000_0014);
    send_byte(8'h04, 1'b1);
    repeat (4) @(negedge clk);
    send_byte(8'h99, 1'b0);
    repeat (10) @(negedge clk);
    send_byte(8'h05, 1'b1);
    drain(1000);

    apply_packet(8'h02, 8'h03, 32'h0000_0006, 3);
    for (int i = 0; i < 100 && tx !== 1'b0; i++) @(negedge clk);
    @(negedge clk);
    check_output("tx_before_reset", tx, 1'b0);
    #2 rstn = 1'b0;
    #1 check_output("tx_async_reset", tx, 1'b1);
    exp_q.delete();
    repeat (3) begin
      @(negedge clk);
      check_output("reset_tx", tx, 1'b1);
    end
    expect_result(32'h0);
    rstn = 1'b1;
    apply_packet(8'hFF, 8'hFF, 32'h0000_0001, 5);
    drain(2000);
    repeat (300) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
